stopwatch_dp: RTL

//   Stopwatch datapath directly downstream of the stopwatch FSM. Consumes the FSM's

---
 rtl/stopwatch_dp.sv | 125 ++++++++++++
 1 files changed

// File: rtl/stopwatch_dp.sv
// Stopwatch datapath: clock divider to a centisecond tick feeding a cascaded
// cs/sec/min/hour counter chain. Optional split/freeze display under STOPWATCH_SPLIT_EN.
module stopwatch_dp #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_runstop,
  input  logic       i_clear,
`ifdef STOPWATCH_SPLIT_EN
  input  logic       i_split,
`endif
  output logic [6:0] o_msec,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_tick
);

  localparam int DIV   = CLK_FREQ / TICK_HZ;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [6:0]       cs_q;
  logic [5:0]       sec_q;
  logic [5:0]       min_q;
  logic [4:0]       hr_q;
  logic             tick_q;
  logic             tick;

  // A tick fires only on a running, non-clearing cycle where the divider wraps.
  assign tick = i_runstop && !i_clear && (div_q == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      cs_q   <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hr_q   <= '0;
      tick_q <= 1'b0;
    end else if (i_clear) begin
      div_q  <= '0;
      cs_q   <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hr_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick;
      if (i_runstop) begin
        div_q <= tick ? '0 : div_q + 1'b1;
      end
      // Whole carry chain resolves in this one edge so no field ever shows an overflow.
      if (tick) begin
        if (cs_q == 7'd99) begin
          cs_q <= '0;
          if (sec_q == 6'd59) begin
            sec_q <= '0;
            if (min_q == 6'd59) begin
              min_q <= '0;
              hr_q  <= (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
            end else begin
              min_q <= min_q + 6'd1;
            end
          end else begin
            sec_q <= sec_q + 6'd1;
          end
        end else begin
          cs_q <= cs_q + 7'd1;
        end
      end
    end
  end

  assign o_tick = tick_q;

`ifdef STOPWATCH_SPLIT_EN
  logic       frozen_q;
  logic [6:0] hold_cs_q;
  logic [5:0] hold_sec_q;
  logic [5:0] hold_min_q;
  logic [4:0] hold_hr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frozen_q   <= 1'b0;
      hold_cs_q  <= '0;
      hold_sec_q <= '0;
      hold_min_q <= '0;
      hold_hr_q  <= '0;
    end else if (i_clear) begin
      frozen_q   <= 1'b0;
      hold_cs_q  <= '0;
      hold_sec_q <= '0;
      hold_min_q <= '0;
      hold_hr_q  <= '0;
    end else if (i_split) begin
      // Each split pulse toggles: capture-and-freeze, then release.
      if (!frozen_q) begin
        frozen_q   <= 1'b1;
        hold_cs_q  <= cs_q;
        hold_sec_q <= sec_q;
        hold_min_q <= min_q;
        hold_hr_q  <= hr_q;
      end else begin
        frozen_q <= 1'b0;
      end
    end
  end

  assign o_msec = frozen_q ? hold_cs_q  : cs_q;
  assign o_sec  = frozen_q ? hold_sec_q : sec_q;
  assign o_min  = frozen_q ? hold_min_q : min_q;
  assign o_hour = frozen_q ? hold_hr_q  : hr_q;
`else
  assign o_msec = cs_q;
  assign o_sec  = sec_q;
  assign o_min  = min_q;
  assign o_hour = hr_q;
`endif

endmodule
